// File: rtl/pwm_capture.sv
// pwm_capture: measures an incoming PWM waveform and recovers its duty value.
//
// pwm_in is synchronised. Each window runs from one rising edge to the next.
// The high cycles and the window length are counted, and a registered report
// is produced with a one-cycle valid strobe. If no rising edge arrives for
// TIMEOUT cycles, a stuck-level report is issued instead. Its value is
// all-ones or zero, following the current input level.
//
// Parameters:
//   CNT_W       width of value; the high count saturates at 2^CNT_W-1
//   TIMEOUT     cycles without a rising edge before a stuck report (> 2^CNT_W)
//   SYNC_STAGES synchroniser depth (>= 2)
//
// Ports:
//   clk    in   system clock
//   rst    in   asynchronous reset, active high
//   pwm_in in   asynchronous PWM input
//   en     in   capture enable; 0 = idle, counters cleared, outputs hold
//   value  out  high-cycle count of the last window (saturated)
//   period out  window length in cycles (saturated)
//   valid  out  one-cycle pulse when value/period/stuck update
//   stuck  out  1 = last report came from a timeout
module pwm_capture #(
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned TIMEOUT     = 512,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pwm_in,
  input  logic             en,
  output logic [CNT_W-1:0] value,
  output logic [CNT_W:0]   period,
  output logic             valid,
  output logic             stuck
);

  // TIMEOUT > 2^CNT_W guarantees CntW >= CNT_W+1, so the slices below are legal.
  localparam int unsigned CntW = $clog2(TIMEOUT + 1);
  localparam logic [CntW-1:0] ValueMax   = CntW'((2 ** CNT_W) - 1);
  localparam logic [CntW-1:0] PeriodMax  = CntW'((2 ** (CNT_W + 1)) - 1);
  localparam logic [CntW-1:0] TimeoutCnt = CntW'(TIMEOUT);

  typedef enum logic [0:0] {StIdle, StMeasure} state_e;

  state_e                 state_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_dly_q;
  logic [CntW-1:0]        per_cnt_q;
  logic [CntW-1:0]        hi_cnt_q;

  logic             s;
  logic             rise;
  logic [CNT_W-1:0] value_sat;
  logic [CNT_W:0]   period_sat;

  assign s    = sync_q[SYNC_STAGES-1];
  assign rise = s & ~s_dly_q;

  always_comb begin
    value_sat  = (hi_cnt_q > ValueMax) ? '1 : hi_cnt_q[CNT_W-1:0];
    period_sat = (per_cnt_q > PeriodMax) ? '1 : per_cnt_q[CNT_W:0];
  end

  // The synchroniser keeps running while en=0, so edge detection remains valid
  // as soon as capture is re-enabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= '0;
      s_dly_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], pwm_in};
      s_dly_q <= s;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      per_cnt_q <= '0;
      hi_cnt_q  <= '0;
      value     <= '0;
      period    <= '0;
      valid     <= 1'b0;
      stuck     <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (!en) begin
        state_q   <= StIdle;
        per_cnt_q <= '0;
        hi_cnt_q  <= '0;
      end else if (rise) begin
        // A rise closes the current window, if one is open, and opens a new one.
        // The edge cycle itself counts toward the new window.
        // The rise is checked before the timeout, so it wins a simultaneous timeout.
        if (state_q == StMeasure) begin
          value  <= value_sat;
          period <= period_sat;
          valid  <= 1'b1;
          stuck  <= 1'b0;
        end
        state_q   <= StMeasure;
        per_cnt_q <= CntW'(1);
        hi_cnt_q  <= CntW'(1);
      end else if (per_cnt_q == TimeoutCnt) begin
        value     <= s ? '1 : '0;
        period    <= '1;
        valid     <= 1'b1;
        stuck     <= 1'b1;
        state_q   <= StIdle;
        per_cnt_q <= CntW'(1);
        hi_cnt_q  <= '0;
      end else begin
        // per_cnt also runs in idle so that a missing first edge still times out.
        per_cnt_q <= per_cnt_q + CntW'(1);
        if (state_q == StMeasure) begin
          hi_cnt_q <= hi_cnt_q + {{(CntW - 1){1'b0}}, s};
        end
      end
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
module tb_pwm_capture;

  localparam int unsigned CNT_W       = 8;
  localparam int unsigned TIMEOUT     = 512;
  localparam int unsigned SYNC_STAGES = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             pwm_in;
  logic             en;
  logic [CNT_W-1:0] value;
  logic [CNT_W:0]   period;
  logic             valid;
  logic             stuck;

  pwm_capture #(
    .CNT_W      (CNT_W),
    .TIMEOUT    (TIMEOUT),
    .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .pwm_in(pwm_in),
    .en    (en),
    .value (value),
    .period(period),
    .valid (valid),
    .stuck (stuck)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int v;
    int p;
    int s;
  } rep_t;

  typedef struct {
    int per;
    int hi;
    int nrise;
    int exp_val;
    int exp_per;
  } vec_t;

  rep_t exp_q[$];
  int   vt_q[$];
  int   rise_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic check(input string name, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  // Scoreboard: every valid pops one expected report.
  task automatic sample();
    rep_t e;
    if (valid) begin
      vt_q.push_back(cyc);
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_valid: got value=%0d period=%0d stuck=%0d expected no report",
                 value, period, stuck);
      end else begin
        e = exp_q.pop_front();
        if (int'(value) != e.v || int'(period) != e.p || int'(stuck) != e.s) begin
          n_fail++;
          $display("FAIL report: got value=%0d period=%0d stuck=%0d expected %0d/%0d/%0d",
                   value, period, stuck, e.v, e.p, e.s);
        end
      end
    end
  endtask

  // Sample at the falling edge, then return 1 time unit after the rising edge.
  task automatic step();
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
  endtask

  task automatic push_rep(input int v, input int p, input int s, input int n);
    rep_t r;
    r.v = v;
    r.p = p;
    r.s = s;
    for (int i = 0; i < n; i++) exp_q.push_back(r);
  endtask

  task automatic drive_wave(input int per, input int hi, input int nrise);
    for (int r = 0; r < nrise; r++) begin
      for (int c = 0; c < per; c++) begin
        pwm_in = (c < hi);
        if (c == 0) rise_q.push_back(cyc);
        step();
      end
    end
    pwm_in = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) step();
    check(name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic do_reset(input logic level);
    rst    = 1'b1;
    en     = 1'b0;
    pwm_in = level;
    repeat (3) step();
    rst = 1'b0;
    en  = 1'b1;
    exp_q.delete();
    vt_q.delete();
    rise_q.delete();
  endtask

  vec_t vecs[7];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    vecs[0] = '{256, 128, 4, 128, 256};
    vecs[1] = '{256, 1,   3, 1,   256};
    vecs[2] = '{256, 255, 3, 255, 256};
    vecs[3] = '{400, 300, 3, 255, 400};
    vecs[4] = '{300, 150, 3, 150, 300};
    vecs[5] = '{10,  3,   4, 3,   10};
    vecs[6] = '{512, 100, 3, 100, 511};

    rst    = 1'b1;
    en     = 1'b0;
    pwm_in = 1'b0;
    repeat (2) step();
    check("reset_value", int'(value), 0);
    check("reset_period", int'(period), 0);
    check("reset_valid", int'(valid), 0);
    check("reset_stuck", int'(stuck), 0);

    // Periodic waveforms: the first rise only opens a window.
    for (int k = 0; k < 7; k++) begin
      do_reset(1'b0);
      repeat (2) step();
      push_rep(vecs[k].exp_val, vecs[k].exp_per, 0, vecs[k].nrise - 1);
      drive_wave(vecs[k].per, vecs[k].hi, vecs[k].nrise);
      wait_drain("periodic_drain", 20);
      for (int r = 1; r < vecs[k].nrise; r++) begin
        lat = (r - 1 < vt_q.size()) ? vt_q[r-1] - rise_q[r] : -1;
        check("edge_to_valid_latency", lat, SYNC_STAGES + 1);
      end
    end

    // Input held low: a stuck report of zero every TIMEOUT cycles.
    do_reset(1'b0);
    push_rep(0, 511, 1, 2);
    wait_drain("stuck_low_drain", 1200);
    lat = (vt_q.size() >= 2) ? vt_q[1] - vt_q[0] : -1;
    check("stuck_low_spacing", lat, TIMEOUT);

    // A normal edge pair after a stuck report clears stuck.
    push_rep(64, 256, 0, 2);
    drive_wave(256, 64, 3);
    wait_drain("after_stuck_drain", 20);
    check("after_stuck_flag", int'(stuck), 0);

    // Held high through reset release: the window opens, then a stuck report of all-ones.
    do_reset(1'b1);
    push_rep(255, 511, 1, 2);
    wait_drain("stuck_high_drain", 1300);
    lat = (vt_q.size() >= 2) ? vt_q[1] - vt_q[0] : -1;
    check("stuck_high_spacing", lat, TIMEOUT);

    // Dropping en: outputs hold, and re-enable needs two rises before a report.
    do_reset(1'b0);
    repeat (2) step();
    push_rep(100, 256, 0, 1);
    drive_wave(256, 100, 2);
    wait_drain("en_pre_drain", 20);
    en = 1'b0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (i == 25) begin
        check("en_hold_value", int'(value), 100);
        check("en_hold_period", int'(period), 256);
      end
    end
    en = 1'b1;
    push_rep(80, 200, 0, 1);
    drive_wave(200, 80, 2);
    wait_drain("en_post_drain", 20);

    // Asynchronous reset in the middle of a window.
    do_reset(1'b0);
    repeat (2) step();
    push_rep(100, 256, 0, 1);
    drive_wave(256, 100, 2);
    wait_drain("rst_pre_drain", 20);
    check("rst_pre_value", int'(value), 100);
    #2;
    rst = 1'b1;
    #1;
    check("rst_async_value", int'(value), 0);
    check("rst_async_period", int'(period), 0);
    check("rst_async_stuck", int'(stuck), 0);
    repeat (2) step();
    rst = 1'b0;
    push_rep(30, 120, 0, 1);
    drive_wave(120, 30, 2);
    wait_drain("rst_post_drain", 20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
